// File: rtl/writeback_controller.sv
// writeback_controller
// Chooses one register-file write per cycle from an unstalled ALU result
// or a buffered load result. ALU results always win; loads wait in a small
// FIFO (FIFO_DEPTH entries, power of two, 2..16) and drain in arrival order.
// Define WB_LOAD_EXT_EN to sign/zero-extend LB/LBU/LH/LHU loads at enqueue;
// without it the raw memory word is stored for every load type.
module writeback_controller #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_byte_off,
    output logic        reg_wr,
    output logic [4:0]  waddr,
    output logic [31:0] wb_data,
    output logic        pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Load FIFO storage; contents are don't-care until written
    logic [4:0]  entryRd_q   [FIFO_DEPTH];
    logic [31:0] entryData_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        regWr_q,  regWr_d;
    logic [4:0]  waddr_q,  waddr_d;
    logic [31:0] wbData_q, wbData_d;

    logic        pushEn;
    logic        popEn;
    logic        selValid;
    logic [4:0]  selRd;
    logic [31:0] selData;
    logic [31:0] loadValue;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Pick the addressed byte/half and extend it so the FIFO holds final register values
    always_comb begin
        case (mem_byte_off)
            2'd0:    loadByte = mem_data[7:0];
            2'd1:    loadByte = mem_data[15:8];
            2'd2:    loadByte = mem_data[23:16];
            default: loadByte = mem_data[31:24];
        endcase
        loadHalf = mem_byte_off[1] ? mem_data[31:16] : mem_data[15:0];
        case (mem_funct3)
            3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadValue = {24'd0, loadByte};
            3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadValue = {16'd0, loadHalf};
            default: loadValue = mem_data;
        endcase
    end
`else
    logic [4:0] unusedLoadInfo;

    // Extension disabled: the raw word is stored and the load-type fields are ignored
    assign loadValue      = mem_data;
    assign unusedLoadInfo = {mem_funct3, mem_byte_off};
`endif

    // Ready depends only on occupancy so a same-cycle pop never frees a slot early
    always_comb begin
        mem_ready = (count_q != FULL_COUNT);
        pending   = (count_q != '0);
        pushEn    = mem_valid && mem_ready;
        popEn     = !alu_valid && (count_q != '0);
    end

    // Arbitration: ALU first, else FIFO head; rd 0 is consumed but never written
    always_comb begin
        selValid = 1'b0;
        selRd    = 5'd0;
        selData  = 32'd0;
        if (alu_valid) begin
            selValid = 1'b1;
            selRd    = alu_rd;
            selData  = alu_result;
        end else if (popEn) begin
            selValid = 1'b1;
            selRd    = entryRd_q[rdPtr_q];
            selData  = entryData_q[rdPtr_q];
        end
    end

    // Next-state for pointers, occupancy and the registered write port
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        regWr_d  = 1'b0;
        waddr_d  = waddr_q;
        wbData_d = wbData_q;

        if (pushEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (selValid && (selRd != 5'd0)) begin
            regWr_d  = 1'b1;
            waddr_d  = selRd;
            wbData_d = selData;
        end
    end

    // State registers; reset drops all buffered loads and any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            regWr_q  <= 1'b0;
            waddr_q  <= 5'd0;
            wbData_q <= 32'd0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            regWr_q  <= regWr_d;
            waddr_q  <= waddr_d;
            wbData_q <= wbData_d;
        end
    end

    // FIFO entry write; storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (pushEn && !reset) begin
            entryRd_q[wrPtr_q]   <= mem_rd;
            entryData_q[wrPtr_q] <= loadValue;
        end
    end

    assign reg_wr  = regWr_q;
    assign waddr   = waddr_q;
    assign wb_data = wbData_q;

endmodule

// File: tb/tb_writeback_controller.sv
// tb_writeback_controller
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the writeback port.
module tb_writeback_controller;

    localparam int DEPTH = 4;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT_ENABLED = 1'b1;
    localparam logic [31:0] EXP_LB  = 32'hFFFFFF80;
    localparam logic [31:0] EXP_LBU = 32'h0000007F;
    localparam logic [31:0] EXP_LH  = 32'hFFFF80FF;
`else
    localparam bit EXT_ENABLED = 1'b0;
    localparam logic [31:0] EXP_LB  = 32'h80FF7F01;
    localparam logic [31:0] EXP_LBU = 32'h80FF7F01;
    localparam logic [31:0] EXP_LH  = 32'h80FF7F01;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_byte_off;
    logic        reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wb_data;
    logic        pending;

    entry_t      modelQ[$];
    logic [4:0]  writeLog[$];
    logic        expRegWr;
    logic [4:0]  expWaddr;
    logic [31:0] expWbData;
    logic        lastAccept;
    int          checkCount = 0;
    int          passCount  = 0;

    writeback_controller #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_funct3   (mem_funct3),
        .mem_byte_off (mem_byte_off),
        .reg_wr       (reg_wr),
        .waddr        (waddr),
        .wb_data      (wb_data),
        .pending      (pending)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Register value a load should produce, from the load-type rules
    function automatic logic [31:0] extendLoad(input logic [31:0] d, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * int'(off))) & 32'hFF;
        h = (d >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // One clock: check combinational status, advance the model, check registered outputs
    task automatic tick();
        logic        accept;
        logic        selValid;
        logic [4:0]  selRd;
        logic [31:0] selData;
        entry_t      e;
        checkOutput("mem_ready", 32'(mem_ready), 32'(modelQ.size() < DEPTH));
        checkOutput("pending", 32'(pending), 32'(modelQ.size() != 0));
        if (reset) begin
            modelQ.delete();
            expRegWr   = 1'b0;
            expWaddr   = 5'd0;
            expWbData  = 32'd0;
            lastAccept = 1'b0;
        end else begin
            accept   = mem_valid && (modelQ.size() < DEPTH);
            selValid = 1'b0;
            selRd    = 5'd0;
            selData  = 32'd0;
            if (alu_valid) begin
                selValid = 1'b1;
                selRd    = alu_rd;
                selData  = alu_result;
            end else if (modelQ.size() != 0) begin
                e        = modelQ.pop_front();
                selValid = 1'b1;
                selRd    = e.rd;
                selData  = e.value;
            end
            if (selValid && selRd != 5'd0) begin
                expRegWr  = 1'b1;
                expWaddr  = selRd;
                expWbData = selData;
            end else begin
                expRegWr  = 1'b0;
            end
            if (accept) begin
                e.rd    = mem_rd;
                e.value = EXT_ENABLED ? extendLoad(mem_data, mem_funct3, mem_byte_off) : mem_data;
                modelQ.push_back(e);
            end
            lastAccept = accept;
        end
        @(posedge clk);
        #1;
        checkOutput("reg_wr", 32'(reg_wr), 32'(expRegWr));
        checkOutput("waddr", 32'(waddr), 32'(expWaddr));
        checkOutput("wb_data", wb_data, expWbData);
        if (reg_wr === 1'b1) writeLog.push_back(waddr);
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                                 input logic [2:0] f3, input logic [1:0] off);
        alu_valid    = av;
        alu_rd       = ard;
        alu_result   = ares;
        mem_valid    = mv;
        mem_rd       = mrd;
        mem_data     = mdat;
        mem_funct3   = f3;
        mem_byte_off = off;
    endtask

    // Push one load into an empty FIFO with no ALU traffic and let it drain
    task automatic loadAndDrain(input logic [4:0] rd, input logic [31:0] d,
                                input logic [2:0] f3, input logic [1:0] off);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, rd, d, f3, off);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
    endtask

    initial begin
        int waitCycles;
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        expRegWr   = 1'b0;
        expWaddr   = 5'd0;
        expWbData  = 32'd0;
        lastAccept = 1'b0;

        // Reset state
        checkOutput("reset_reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("reset_waddr", 32'(waddr), 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("reset_pending", 32'(pending), 32'd0);

        // Single ALU write, then idle
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        checkOutput("alu_reg_wr", 32'(reg_wr), 32'd1);
        checkOutput("alu_waddr", 32'(waddr), 32'd5);
        checkOutput("alu_wb_data", wb_data, 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        checkOutput("idle_reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("idle_waddr_hold", 32'(waddr), 32'd5);

        // Load held behind three ALU cycles
        applyStimulus(1'b1, 5'd3, 32'h1111, 1'b1, 5'd7, 32'h12345678, 3'b010, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h2222, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd6, 32'h3333, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        checkOutput("starve_pending", 32'(pending), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        checkOutput("load_waddr", 32'(waddr), 32'd7);
        checkOutput("load_wb_data", wb_data, 32'h12345678);
        checkOutput("load_done_pending", 32'(pending), 32'd0);

        // Fill past capacity under continuous ALU traffic to rd 0
        writeLog.delete();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'(11 + i), 32'(100 + i), 3'b010, 2'd0);
            tick();
        end
        checkOutput("full_mem_ready", 32'(mem_ready), 32'd0);
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd15, 32'd104, 3'b010, 2'd0);
        tick();
        tick();
        checkOutput("full_held", 32'(lastAccept), 32'd0);
        alu_valid  = 1'b0;
        waitCycles = 0;
        do begin
            tick();
            waitCycles++;
        end while (!lastAccept && waitCycles < 20);
        checkOutput("fifth_accepted", 32'(lastAccept), 32'd1);
        mem_valid = 1'b0;
        repeat (DEPTH + 2) tick();
        checkOutput("drain_count", 32'(writeLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < writeLog.size(); i++) begin
            checkOutput("drain_order", 32'(writeLog[i]), 32'(11 + i));
        end

        // Load extension cases
        loadAndDrain(5'd9, 32'h80FF7F01, 3'b000, 2'd3);
        checkOutput("lb_off3", wb_data, EXP_LB);
        loadAndDrain(5'd9, 32'h80FF7F01, 3'b100, 2'd1);
        checkOutput("lbu_off1", wb_data, EXP_LBU);
        loadAndDrain(5'd9, 32'h80FF7F01, 3'b001, 2'd2);
        checkOutput("lh_off2", wb_data, EXP_LH);

        // Destination 0 from both sources
        applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        tick();
        checkOutput("alu_rd0_reg_wr", 32'(reg_wr), 32'd0);
        loadAndDrain(5'd0, 32'h55AA55AA, 3'b010, 2'd0);
        checkOutput("load_rd0_reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("load_rd0_pending", 32'(pending), 32'd0);
        checkOutput("rd0_wb_data_hold", wb_data, EXP_LH);

        // Reset with three buffered loads
        writeLog.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'(200 + i), 3'b010, 2'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("rst_reg_wr", 32'(reg_wr), 32'd0);
        repeat (4) tick();
        checkOutput("rst_no_writes", 32'(writeLog.size()), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [2:0] f3;
            case ($urandom_range(0, 5))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b010;
                3:       f3 = 3'b100;
                4:       f3 = 3'b101;
                default: f3 = 3'($urandom);
            endcase
            applyStimulus($urandom_range(0, 2) == 0,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                          $urandom,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                          $urandom, f3, 2'($urandom));
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/writeback_controller.md
WRITEBACK_CONTROLLER -- requirements
Module: writeback_controller

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of load-result entries buffered; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_result  input  32  ALU result.
REQ-007 mem_valid  input  1  load result offered.
REQ-008 mem_ready  output  1  load result accepted when mem_valid && mem_ready.
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  32  raw memory word.
REQ-011 mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 mem_byte_off  input  2  address bits [1:0] of the load.
REQ-013 reg_wr  output  1  register-file write enable.
REQ-014 waddr  output  5  register-file write address.
REQ-015 wb_data  output  32  register-file write data.
REQ-016 pending  output  1  high while the load FIFO is non-empty.

Function
REQ-017 Outputs reg_wr, waddr and wb_data shall be registered; a selected result appears exactly 1 cycle after selection.
REQ-018 The load FIFO shall accept an entry when mem_valid && mem_ready; mem_ready = FIFO not full (no dependence on mem_valid or on a same-cycle pop).
REQ-019 Arbitration each cycle: alu_valid wins; otherwise, if the FIFO is non-empty, the head entry is popped and written; otherwise reg_wr = 0 next cycle.
REQ-020 ALU priority is strict; load starvation under continuous alu_valid is permitted; the FIFO holds entries intact.
REQ-021 A selected result with destination 0 shall be consumed (popped, if from the FIFO) but shall produce reg_wr = 0.
REQ-022 When reg_wr = 0, waddr and wb_data shall hold their previous values.
REQ-023 Simultaneous push and pop on a non-full FIFO shall both take effect; occupancy is unchanged.
REQ-024 FIFO order shall be strict first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width = log2(FIFO_DEPTH)+1.
REQ-025 Load extension shall be applied at enqueue; the stored value is the final 32-bit register value.
REQ-026 pending shall be combinational from occupancy (occupancy != 0).

Reset
REQ-027 On reset: reg_wr = 0, waddr = 0, wb_data = 0, FIFO pointers and occupancy = 0, so mem_ready = 1 and pending = 0 in the following cycle.
REQ-028 Reset mid-operation shall discard all buffered loads and any in-flight write; no write shall occur in the cycle after reset is sampled high.
REQ-029 FIFO storage contents need not be cleared by reset.

Configuration
REQ-030 Macro WB_LOAD_EXT_EN defined: LB/LBU select byte mem_byte_off and sign/zero-extend it; LH/LHU select the half mem_byte_off[1] and sign/zero-extend it; LW and any other funct3 pass mem_data unchanged.
REQ-031 Macro WB_LOAD_EXT_EN undefined: mem_data is stored unmodified for every funct3; mem_funct3 and mem_byte_off are ignored.

Verification
REQ-032 Reset, then alu_valid=1, alu_rd=5, alu_result=0xDEADBEEF for 1 cycle -> next cycle reg_wr=1, waddr=5, wb_data=0xDEADBEEF; following cycle reg_wr=0.
REQ-033 alu_valid=1 held 3 cycles while one load (rd=7, data=0x12345678, LW) is pushed -> loads hold; pending=1; write rd=7 appears 1 cycle after alu_valid drops.
REQ-034 Push 5 loads back-to-back with alu_valid=1 and FIFO_DEPTH=4 -> mem_ready=0 after 4th accept; 5th held by source; drain order matches push order.
REQ-035 With WB_LOAD_EXT_EN: mem_data=0x80FF7F01, LB, offset 3 -> wb_data=0xFFFFFF80; LBU, offset 1 -> 0x0000007F; LH, offset 2 -> 0xFFFF80FF; without macro -> 0x80FF7F01 for all.
REQ-036 ALU result with alu_rd=0, then load with rd=0 -> reg_wr stays 0 both cycles; FIFO entry popped; pending returns to 0.
REQ-037 Three loads buffered, reset asserted 1 cycle -> next cycle pending=0, mem_ready=1, reg_wr=0; no buffered load is ever written.
